// File: rtl/clk_run_ctrl_if.sv
// Front-panel / CPU-side bundle of the run-mode controller.
// The panel (master) drives the request levels; the controller (slave) drives tick and status.
interface clk_run_ctrl_if;
    // Signal semantics: run_en, HALT and resume are levels, sampled on every CLK edge.
    // step_req is a level whose rising edge is a request. cpu_tick is a one-CLK-wide
    // enable pulse with no back-pressure. mode, halt_blink and tick_cnt are registered status.
    logic        run_en;
    logic        step_req;
    logic        HALT;
    logic        resume;
    logic        cpu_tick;
    logic        halt_blink;
    logic [1:0]  mode;
    logic [15:0] tick_cnt;

    modport master (
        output run_en, step_req, HALT, resume,
        input  cpu_tick, halt_blink, mode, tick_cnt
    );

    modport slave (
        input  run_en, step_req, HALT, resume,
        output cpu_tick, halt_blink, mode, tick_cnt
    );
endinterface

// File: rtl/clk_run_ctrl.sv
// Run-mode controller: turns the board clock into CPU clock-enable pulses in
// free-run, single-step or halted operation. The registered mode is the FSM state.
module clk_run_ctrl #(
    parameter int RUN_DIV   = 25000000,
    parameter int BLINK_DIV = 7500000,
    parameter int CNT_W     = 32
) (
    input  logic               CLK,
    input  logic               clr,
    clk_run_ctrl_if.slave      bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        STEP   = 2'b10,
        HALTED = 2'b11
    } mode_e;

    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(RUN_DIV - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    mode_e             mode_q, mode_d;
    logic              cpu_tick_q, cpu_tick_d;
    logic              halt_blink_q, halt_blink_d;
    logic [15:0]       tick_cnt_q, tick_cnt_d;
    logic [CNT_W-1:0]  div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic              step_q, step_d;
    logic              step_rise;

    assign step_rise = bus.step_req & ~step_q;

    always_comb begin
        mode_d       = mode_q;
        cpu_tick_d   = 1'b0;
        halt_blink_d = halt_blink_q;
        tick_cnt_d   = tick_cnt_q;
        div_cnt_d    = div_cnt_q;
        blink_cnt_d  = blink_cnt_q;
        step_d       = bus.step_req;

        unique case (mode_q)
            IDLE: begin
                if (bus.HALT) begin
                    mode_d       = HALTED;
                    blink_cnt_d  = '0;
                    halt_blink_d = 1'b1;
                end else if (bus.run_en) begin
                    // A step press coinciding with run_en is dropped in favour of RUN.
                    mode_d    = RUN;
                    div_cnt_d = '0;
                end else if (step_rise) begin
                    mode_d     = STEP;
                    cpu_tick_d = 1'b1;
                end
            end

            RUN: begin
                if (bus.HALT) begin
                    mode_d       = HALTED;
                    div_cnt_d    = '0;
                    blink_cnt_d  = '0;
                    halt_blink_d = 1'b1;
                end else if (!bus.run_en) begin
                    mode_d    = IDLE;
                    div_cnt_d = '0;
                end else if (div_cnt_q == RUN_LAST) begin
                    cpu_tick_d = 1'b1;
                    div_cnt_d  = '0;
                end else begin
                    div_cnt_d = div_cnt_q + CNT_ONE;
                end
            end

            STEP: begin
                if (bus.HALT) begin
                    mode_d       = HALTED;
                    blink_cnt_d  = '0;
                    halt_blink_d = 1'b1;
                end else begin
                    mode_d = IDLE;
                end
            end

            HALTED: begin
                // Only an explicit resume with HALT released leaves; HALT falling alone does not.
                if (bus.resume && !bus.HALT) begin
                    mode_d       = IDLE;
                    halt_blink_d = 1'b1;
                    blink_cnt_d  = '0;
                end else if (blink_cnt_q == BLINK_LAST) begin
                    halt_blink_d = ~halt_blink_q;
                    blink_cnt_d  = '0;
                end else begin
                    blink_cnt_d = blink_cnt_q + CNT_ONE;
                end
            end

            default: mode_d = IDLE;
        endcase

        if (cpu_tick_d) begin
            tick_cnt_d = tick_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        step_q <= step_d;
        if (clr) begin
            mode_q       <= IDLE;
            cpu_tick_q   <= 1'b0;
            halt_blink_q <= 1'b1;
            tick_cnt_q   <= '0;
            div_cnt_q    <= '0;
            blink_cnt_q  <= '0;
        end else begin
            mode_q       <= mode_d;
            cpu_tick_q   <= cpu_tick_d;
            halt_blink_q <= halt_blink_d;
            tick_cnt_q   <= tick_cnt_d;
            div_cnt_q    <= div_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
        end
    end

    assign bus.cpu_tick   = cpu_tick_q;
    assign bus.halt_blink = halt_blink_q;
    assign bus.mode       = mode_q;
    assign bus.tick_cnt   = tick_cnt_q;

endmodule

// File: tb/tb_clk_run_ctrl.sv
// Bench for clk_run_ctrl: directed scenarios plus random stimulus, each checked
// against a cycles-since-mode-entry model of the controller.
module tb_clk_run_ctrl;

    localparam int RUN_DIV   = 4;
    localparam int BLINK_DIV = 2;

    localparam logic [1:0] M_IDLE   = 2'b00;
    localparam logic [1:0] M_RUN    = 2'b01;
    localparam logic [1:0] M_STEP   = 2'b10;
    localparam logic [1:0] M_HALTED = 2'b11;

    logic CLK = 1'b0;
    logic clr;

    clk_run_ctrl_if bus ();

    clk_run_ctrl #(
        .RUN_DIV   (RUN_DIV),
        .BLINK_DIV (BLINK_DIV),
        .CNT_W     (32)
    ) dut (
        .CLK (CLK),
        .clr (clr),
        .bus (bus)
    );

    initial forever #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: mode plus age = cycles spent in the current mode.
    logic [1:0]  m_mode  = M_IDLE;
    logic        m_tick  = 1'b0;
    logic        m_blink = 1'b1;
    logic [15:0] m_cnt   = 16'h0;
    int          m_age   = 0;
    logic        m_prev  = 1'b0;

    task automatic model_step();
        logic       rise;
        logic [1:0] nxt;
        if (clr) begin
            m_mode  = M_IDLE;
            m_tick  = 1'b0;
            m_blink = 1'b1;
            m_cnt   = 16'h0;
            m_age   = 0;
            m_prev  = bus.step_req;
        end else begin
            rise   = bus.step_req && !m_prev;
            m_prev = bus.step_req;
            case (m_mode)
                M_IDLE:  nxt = bus.HALT ? M_HALTED : bus.run_en ? M_RUN : rise ? M_STEP : M_IDLE;
                M_RUN:   nxt = bus.HALT ? M_HALTED : !bus.run_en ? M_IDLE : M_RUN;
                M_STEP:  nxt = bus.HALT ? M_HALTED : M_IDLE;
                default: nxt = (bus.resume && !bus.HALT) ? M_IDLE : M_HALTED;
            endcase
            m_age   = (nxt == m_mode) ? m_age + 1 : 0;
            m_tick  = (nxt == M_STEP) || (nxt == M_RUN && m_mode == M_RUN && (m_age % RUN_DIV) == 0);
            m_blink = (nxt == M_HALTED) ? (((m_age / BLINK_DIV) % 2) == 0) : 1'b1;
            m_cnt   = m_cnt + {15'h0, m_tick};
            m_mode  = nxt;
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        clr = 1'b1;
        bus.step_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_checks++;
            if ({bus.cpu_tick, bus.halt_blink, bus.mode, bus.tick_cnt} !== {1'b0, 1'b1, M_IDLE, 16'h0}) begin
                n_fail++;
                $display("FAIL reset_hold got=%h want=%h", {bus.cpu_tick, bus.halt_blink, bus.mode, bus.tick_cnt}, {1'b0, 1'b1, M_IDLE, 16'h0});
            end
        end
        clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_checks++;
            if ({bus.cpu_tick, bus.halt_blink, bus.mode, bus.tick_cnt} !== {m_tick, m_blink, m_mode, m_cnt} || bus.cpu_tick !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_held_step got=%h want=%h", {bus.cpu_tick, bus.halt_blink, bus.mode, bus.tick_cnt}, {1'b0, 1'b1, M_IDLE, 16'h0});
            end
        end
        bus.step_req = 1'b0;
        cyc();
    endtask

    task automatic test_free_run();
        int          ticks = 0;
        logic [15:0] base  = m_cnt;
        bus.run_en = 1'b1;
        cyc();
        n_checks++;
        if (bus.mode !== M_RUN) begin
            n_fail++;
            $display("FAIL run_entry mode got=%0d want=%0d", bus.mode, M_RUN);
        end
        for (int i = 1; i <= 12; i++) begin
            cyc();
            ticks += int'(bus.cpu_tick);
            n_checks++;
            if (bus.cpu_tick !== ((i % RUN_DIV) == 0) || bus.mode !== m_mode || bus.tick_cnt !== m_cnt) begin
                n_fail++;
                $display("FAIL run_tick age=%0d got tick=%0d mode=%0d cnt=%0d want tick=%0d mode=%0d cnt=%0d",
                         i, bus.cpu_tick, bus.mode, bus.tick_cnt, (i % RUN_DIV) == 0, m_mode, m_cnt);
            end
        end
        n_checks++;
        if (ticks != 3 || bus.tick_cnt !== base + 16'd3) begin
            n_fail++;
            $display("FAIL run_count got ticks=%0d cnt=%0d want ticks=3 cnt=%0d", ticks, bus.tick_cnt, base + 16'd3);
        end
        bus.run_en = 1'b0;
        cyc();
        n_checks++;
        if (bus.mode !== M_IDLE || bus.cpu_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL run_stop got mode=%0d tick=%0d want mode=0 tick=0", bus.mode, bus.cpu_tick);
        end
        for (int i = 0; i < 8; i++) begin
            cyc();
            n_checks++;
            if (bus.cpu_tick !== 1'b0 || bus.tick_cnt !== base + 16'd3) begin
                n_fail++;
                $display("FAIL run_idle_quiet got tick=%0d cnt=%0d want tick=0 cnt=%0d", bus.cpu_tick, bus.tick_cnt, base + 16'd3);
            end
        end
    endtask

    task automatic test_single_step();
        int          ticks = 0;
        logic [15:0] base;
        bus.step_req = 1'b0;
        cyc();
        base = m_cnt;
        bus.step_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            ticks += int'(bus.cpu_tick);
            n_checks++;
            if (bus.cpu_tick !== (i == 0) || bus.mode !== ((i == 0) ? M_STEP : M_IDLE)) begin
                n_fail++;
                $display("FAIL step_press cyc=%0d got tick=%0d mode=%0d want tick=%0d mode=%0d",
                         i, bus.cpu_tick, bus.mode, i == 0, (i == 0) ? M_STEP : M_IDLE);
            end
        end
        bus.step_req = 1'b0;
        cyc();
        for (int p = 0; p < 3; p++) begin
            bus.step_req = 1'b1;
            cyc();
            bus.step_req = 1'b0;
            cyc();
            cyc();
        end
        n_checks++;
        if (ticks != 1 || bus.tick_cnt !== base + 16'd4 || m_cnt !== base + 16'd4) begin
            n_fail++;
            $display("FAIL step_count got ticks=%0d cnt=%0d want ticks=1 cnt=%0d", ticks, bus.tick_cnt, base + 16'd4);
        end
        bus.step_req = 1'b1;
        bus.run_en   = 1'b1;
        cyc();
        n_checks++;
        if (bus.mode !== M_RUN || bus.cpu_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL step_vs_run got mode=%0d tick=%0d want mode=1 tick=0", bus.mode, bus.cpu_tick);
        end
        bus.run_en   = 1'b0;
        bus.step_req = 1'b0;
        cyc();
    endtask

    task automatic test_halt();
        logic found = 1'b0;
        bus.run_en = 1'b1;
        cyc();
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_mode == M_RUN && (m_age % RUN_DIV) == RUN_DIV - 1) found = 1'b1;
            else cyc();
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL halt_wait got timeout want due-tick point");
        end
        bus.HALT = 1'b1;
        cyc();
        n_checks++;
        if (bus.mode !== M_HALTED || bus.cpu_tick !== 1'b0 || bus.halt_blink !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_entry got mode=%0d tick=%0d blink=%0d want mode=3 tick=0 blink=1", bus.mode, bus.cpu_tick, bus.halt_blink);
        end
        for (int i = 1; i <= 9; i++) begin
            cyc();
            n_checks++;
            if (bus.halt_blink !== (((i / BLINK_DIV) % 2) == 0) || bus.cpu_tick !== 1'b0 || bus.mode !== M_HALTED) begin
                n_fail++;
                $display("FAIL halt_blink age=%0d got blink=%0d tick=%0d mode=%0d want blink=%0d tick=0 mode=3",
                         i, bus.halt_blink, bus.cpu_tick, bus.mode, ((i / BLINK_DIV) % 2) == 0);
            end
        end
        bus.HALT   = 1'b0;
        bus.run_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_checks++;
            if (bus.mode !== M_HALTED || bus.halt_blink !== m_blink) begin
                n_fail++;
                $display("FAIL halt_no_resume got mode=%0d blink=%0d want mode=3 blink=%0d", bus.mode, bus.halt_blink, m_blink);
            end
        end
        bus.resume = 1'b1;
        cyc();
        n_checks++;
        if (bus.mode !== M_IDLE || bus.halt_blink !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_resume got mode=%0d blink=%0d want mode=0 blink=1", bus.mode, bus.halt_blink);
        end
        bus.resume = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid();
        logic found = 1'b0;
        bus.run_en = 1'b1;
        cyc();
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_mode == M_RUN && (m_age % RUN_DIV) == 2) found = 1'b1;
            else cyc();
        end
        clr = 1'b1;
        cyc();
        n_checks++;
        if (!found || {bus.cpu_tick, bus.halt_blink, bus.mode, bus.tick_cnt} !== {1'b0, 1'b1, M_IDLE, 16'h0}) begin
            n_fail++;
            $display("FAIL reset_mid_run found=%0d got=%h want=%h", found, {bus.cpu_tick, bus.halt_blink, bus.mode, bus.tick_cnt}, {1'b0, 1'b1, M_IDLE, 16'h0});
        end
        clr = 1'b0;
        bus.HALT = 1'b1;
        cyc();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_mode == M_HALTED && m_blink == 1'b0) found = 1'b1;
            else cyc();
        end
        clr = 1'b1;
        cyc();
        n_checks++;
        if (!found || {bus.cpu_tick, bus.halt_blink, bus.mode, bus.tick_cnt} !== {1'b0, 1'b1, M_IDLE, 16'h0}) begin
            n_fail++;
            $display("FAIL reset_mid_halt found=%0d got=%h want=%h", found, {bus.cpu_tick, bus.halt_blink, bus.mode, bus.tick_cnt}, {1'b0, 1'b1, M_IDLE, 16'h0});
        end
        clr = 1'b0;
        bus.HALT   = 1'b0;
        bus.run_en = 1'b0;
        cyc();
    endtask

    task automatic test_wrap();
        logic seen_wrap = 1'b0;
        logic [15:0] prev;
        bus.run_en = 1'b1;
        cyc();
        force dut.tick_cnt_q = 16'hFFF0;
        m_cnt = 16'hFFF0;
        #1;
        release dut.tick_cnt_q;
        n_checks++;
        if (bus.tick_cnt !== 16'hFFF0) begin
            n_fail++;
            $display("FAIL wrap_preload got=%h want=fff0", bus.tick_cnt);
        end
        prev = m_cnt;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (prev == 16'hFFFF && bus.tick_cnt == 16'h0000) seen_wrap = 1'b1;
            prev = bus.tick_cnt;
            n_checks++;
            if (bus.tick_cnt !== m_cnt || bus.mode !== M_RUN || bus.cpu_tick !== m_tick) begin
                n_fail++;
                $display("FAIL wrap_run got cnt=%h mode=%0d tick=%0d want cnt=%h mode=1 tick=%0d",
                         bus.tick_cnt, bus.mode, bus.cpu_tick, m_cnt, m_tick);
            end
        end
        n_checks++;
        if (!seen_wrap) begin
            n_fail++;
            $display("FAIL wrap_seen got=0 want=1");
        end
        bus.run_en = 1'b0;
        cyc();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15, 0) == 0) bus.run_en = ~bus.run_en;
            if ($urandom_range(2, 0) == 0)  bus.step_req = ~bus.step_req;
            if ($urandom_range(29, 0) == 0) bus.HALT = ~bus.HALT;
            bus.resume = ($urandom_range(7, 0) == 0);
            clr        = ($urandom_range(199, 0) == 0);
            cyc();
            n_checks++;
            if ({bus.cpu_tick, bus.halt_blink, bus.mode, bus.tick_cnt} !== {m_tick, m_blink, m_mode, m_cnt}) begin
                n_fail++;
                $display("FAIL random cyc=%0d got tick=%0d blink=%0d mode=%0d cnt=%h want tick=%0d blink=%0d mode=%0d cnt=%h",
                         i, bus.cpu_tick, bus.halt_blink, bus.mode, bus.tick_cnt, m_tick, m_blink, m_mode, m_cnt);
            end
        end
        clr = 1'b0;
        bus.run_en = 1'b0;
        bus.step_req = 1'b0;
        bus.HALT = 1'b0;
        bus.resume = 1'b1;
        cyc();
        bus.resume = 1'b0;
        cyc();
    endtask

    initial begin
        clr          = 1'b1;
        bus.run_en   = 1'b0;
        bus.step_req = 1'b0;
        bus.HALT     = 1'b0;
        bus.resume   = 1'b0;
        test_reset();
        test_free_run();
        test_single_step();
        test_halt();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
